// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_pkg
//  Purpose  : Shared state codes, quarter indices and divider helper for the
//             byte-level I2C master.
//  Revision : 1.0
// ============================================================================
package i2c_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] BIT   = 3'd2;
    localparam logic [2:0] ACK   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    function automatic int qdiv(input int clk_freq, input int scl_freq);
        return clk_freq / (4 * scl_freq);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_qtr_tick.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_qtr_tick
//  Purpose  : Quarter-bit divider; one-cycle strobe on the last cycle of each
//             quarter, counter cleared while disabled and frozen on hold.
//  Revision : 1.0
// ============================================================================
module i2c_qtr_tick #(
    parameter int QDIV = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic hold,
    output logic tick
);

    localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = enable && !hold && (r_cnt == CW'(QDIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!enable) begin
            r_cnt <= '0;
        end else if (hold) begin
            r_cnt <= r_cnt;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_byte_master.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_byte_master
//  Purpose  : Byte-level I2C master: optional START, 8 data bits, ACK slot,
//             optional STOP. Optional clock stretching: I2C_CLK_STRETCH_EN.
//  Revision : 1.0
// ============================================================================
module i2c_byte_master
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int SCL_FREQ = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       cmd_nack,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       ack_err,
    output logic       done,
    inout  wire        i2c_scl,
    inout  wire        i2c_sda
);

    localparam int QDIV = qdiv(CLK_FREQ, SCL_FREQ);

    logic [2:0] r_state;
    logic [1:0] r_qtr;
    logic [2:0] r_bit;
    logic       r_stop, r_read, r_nack;
    logic [7:0] r_tx, r_shift;
    logic       r_scl_low, r_sda_low;
    logic [1:0] r_sda_sync;

    logic       w_accept, w_busy, w_tick, w_hold, w_load, w_sda_bit;
    logic [2:0] w_ph, w_bit;
    logic [1:0] w_q;
    logic [7:0] w_tx;
    logic       w_rd;

    assign i2c_scl = r_scl_low ? 1'b0 : 1'bz;
    assign i2c_sda = r_sda_low ? 1'b0 : 1'bz;

    assign w_accept = cmd_valid && cmd_ready;
    assign w_busy   = (r_state == START) || (r_state == BIT) ||
                      (r_state == ACK)   || (r_state == STOP);

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] r_scl_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_scl_sync <= 2'b11;
        else     r_scl_sync <= {r_scl_sync[0], i2c_scl};
    end

    // Synchroniser latency adds two cycles to every q2 that follows our own SCL release.
    assign w_hold = (r_qtr == Q2) && !r_scl_sync[1];
`else
    assign w_hold = 1'b0;
`endif

    i2c_qtr_tick #(.QDIV(QDIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (w_busy),
        .hold   (w_hold),
        .tick   (w_tick)
    );

    // Destination phase/quarter for the next load, either from acceptance or a quarter end.
    always_comb begin
        w_load = 1'b0;
        w_ph   = r_state;
        w_q    = r_qtr;
        w_bit  = r_bit;
        if (w_accept) begin
            w_load = 1'b1;
            w_ph   = cmd_start ? START : BIT;
            w_q    = Q0;
            w_bit  = 3'd0;
        end else if (w_tick) begin
            w_load = 1'b1;
            w_q    = r_qtr + 2'd1;
            if (r_qtr == Q3) begin
                case (r_state)
                    START:   begin w_ph = BIT; w_bit = 3'd0; end
                    BIT:     if (r_bit == 3'd7) w_ph = ACK; else w_bit = r_bit + 3'd1;
                    ACK:     w_ph = r_stop ? STOP : DONE;
                    default: w_ph = DONE;
                endcase
            end
        end
    end

    assign w_tx      = w_accept ? tx_data  : r_tx;
    assign w_rd      = w_accept ? cmd_read : r_read;
    assign w_sda_bit = !w_rd && !w_tx[3'd7 - w_bit];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_qtr      <= Q0;
            r_bit      <= 3'd0;
            r_stop     <= 1'b0;
            r_read     <= 1'b0;
            r_nack     <= 1'b0;
            r_tx       <= 8'h00;
            r_shift    <= 8'h00;
            r_scl_low  <= 1'b0;
            r_sda_low  <= 1'b0;
            r_sda_sync <= 2'b11;
            cmd_ready  <= 1'b1;
            rx_data    <= 8'h00;
            ack_err    <= 1'b0;
            done       <= 1'b0;
        end else begin
            r_sda_sync <= {r_sda_sync[0], i2c_sda};
            done       <= w_load && (w_ph == DONE);

            if (w_accept) begin
                r_stop    <= cmd_stop;
                r_read    <= cmd_read;
                r_nack    <= cmd_nack;
                r_tx      <= tx_data;
                ack_err   <= 1'b0;
                cmd_ready <= 1'b0;
            end

            if (w_tick && (r_qtr == Q2)) begin
                if (r_state == BIT) r_shift <= {r_shift[6:0], r_sda_sync[1]};
                if (r_state == ACK) ack_err <= !r_read && r_sda_sync[1];
            end

            if (w_load) begin
                r_state <= w_ph;
                r_qtr   <= w_q;
                r_bit   <= w_bit;
                case (w_ph)
                    START: begin
                        if (w_q == Q0) r_sda_low <= 1'b0;
                        if (w_q == Q1) r_scl_low <= 1'b0;
                        if (w_q == Q2) r_sda_low <= 1'b1;
                    end
                    BIT, ACK: begin
                        if (w_q == Q0) begin
                            r_scl_low <= 1'b1;
                            r_sda_low <= (w_ph == BIT) ? w_sda_bit : (r_read && !r_nack);
                        end
                        if (w_q == Q2) r_scl_low <= 1'b0;
                    end
                    STOP: begin
                        if (w_q == Q0) begin
                            r_scl_low <= 1'b1;
                            r_sda_low <= 1'b1;
                        end
                        if (w_q == Q1) r_scl_low <= 1'b0;
                        if (w_q == Q2) r_sda_low <= 1'b0;
                    end
                    DONE: begin
                        // Without STOP the bus stays owned: SCL parked low.
                        if (!r_stop) r_scl_low <= 1'b1;
                        if (r_read)  rx_data   <= r_shift;
                    end
                    default: ;
                endcase
            end else if (r_state == DONE) begin
                r_state   <= IDLE;
                cmd_ready <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_byte_master
//  Purpose  : Directed, table-driven bench with a bit-level slave model.
//  Revision : 1.0
// ============================================================================
module tb_i2c_byte_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0;
    logic       cmd_read = 1'b0, cmd_nack = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       cmd_ready, ack_err, done;
    logic [7:0] rx_data;
    wire        i2c_scl, i2c_sda;

    pullup(i2c_scl);
    pullup(i2c_sda);

    always #5 clk = ~clk;

    // QDIV = 10: each phase is 40 cycles
    i2c_byte_master #(.CLK_FREQ(4_000_000), .SCL_FREQ(100_000)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_read(cmd_read),
        .cmd_nack(cmd_nack), .tx_data(tx_data), .rx_data(rx_data),
        .ack_err(ack_err), .done(done), .i2c_scl(i2c_scl), .i2c_sda(i2c_sda)
    );

    // Slave: plan bit (8-k) is what it puts on SDA for bit k (1 = release).
    logic       s_drive_low = 1'b0;
    logic       s_scl_low   = 1'b0;
    logic [8:0] s_plan      = 9'h1FF;
    logic       s_start     = 1'b0;
    logic [8:0] s_bus       = 9'h000;
    int         arm_cnt     = 0;

    assign i2c_sda = s_drive_low ? 1'b0 : 1'bz;
    assign i2c_scl = s_scl_low   ? 1'b0 : 1'bz;

    initial begin : slave
        int  bitcnt   = 10;
        int  prev_arm = 0;
        logic prev_scl = 1'b1, prev_sda = 1'b1;
        forever begin
            @(i2c_scl or i2c_sda or arm_cnt);
            #1;
            if (arm_cnt != prev_arm) begin
                prev_arm    = arm_cnt;
                bitcnt      = 0;
                s_bus       = 9'h000;
                s_drive_low = s_start ? 1'b0 : !s_plan[8];
            end
            if (i2c_scl && !prev_scl) begin
                if (bitcnt < 9) s_bus = {s_bus[7:0], i2c_sda};
                bitcnt++;
            end else if (!i2c_scl && prev_scl) begin
                s_drive_low = (bitcnt < 9) ? !s_plan[8 - bitcnt] : 1'b0;
            end else if (!i2c_sda && prev_sda && i2c_scl) begin
                bitcnt = 0;
            end
            prev_scl = i2c_scl;
            prev_sda = i2c_sda;
        end
    end

    typedef struct {
        logic       start, stop, rd, nack;
        logic [7:0] tx;
        logic [8:0] plan;
        logic [8:0] exp_bus;
        logic [7:0] exp_rx;
        logic       exp_err;
        int         exp_cyc;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one command and returns cycles from acceptance to the done pulse.
    task automatic issue(input vec_t v, input int valid_hold, output int cyc, output int n_done);
        int guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 2000) begin @(negedge clk); guard++; end
        chk("ready_before_issue", {31'd0, cmd_ready}, 32'd1);
        cmd_start = v.start; cmd_stop = v.stop; cmd_read = v.rd;
        cmd_nack  = v.nack;  tx_data  = v.tx;   cmd_valid = 1'b1;
        s_plan = v.plan; s_start = v.start; arm_cnt++;
        @(posedge clk);
        @(negedge clk);
        cyc = 1; n_done = 0;
        tx_data = 8'hFF; cmd_start = 1'b0; cmd_read = ~v.rd;
        if (valid_hold == 0) cmd_valid = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc >= valid_hold) cmd_valid = 1'b0;
        end
        if (done) n_done++;
        cmd_valid = 1'b0;
    endtask

    vec_t vecs [10];

    initial begin : main
        int cyc, nd, extra;
        vec_t v;
        //            start stop rd nack tx     plan    bus     rx     err cyc
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA0, 9'h1FE, 9'h140, 8'h00, 1'b0, 401};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'h1FE, 9'h000, 8'h00, 1'b0, 361};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 9'h1FE, 9'h0B4, 8'h00, 1'b0, 401};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA0, 9'h1FE, 9'h140, 8'h00, 1'b0, 401};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'h1FE, 9'h000, 8'h00, 1'b0, 361};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA1, 9'h1FE, 9'h142, 8'h00, 1'b0, 401};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 9'h0B5, 9'h0B5, 8'h5A, 1'b0, 401};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hAE, 9'h1FF, 9'h15D, 8'h5A, 1'b1, 441};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 9'h187, 9'h186, 8'hC3, 1'b0, 401};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 9'h079, 9'h079, 8'h3C, 1'b0, 401};

        repeat (3) @(negedge clk);
        chk("reset_ready",   {31'd0, cmd_ready}, 32'd1);
        chk("reset_done",    {31'd0, done},      32'd0);
        chk("reset_ack_err", {31'd0, ack_err},   32'd0);
        chk("reset_rx_data", {24'd0, rx_data},   32'd0);
        chk("reset_scl",     {31'd0, i2c_scl},   32'd1);
        chk("reset_sda",     {31'd0, i2c_sda},   32'd1);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i], 0, cyc, nd);
            chk($sformatf("v%0d_latency", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("v%0d_bus_bits", i), {23'd0, s_bus}, {23'd0, vecs[i].exp_bus});
            chk($sformatf("v%0d_rx_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_rx});
            chk($sformatf("v%0d_ack_err", i), {31'd0, ack_err}, {31'd0, vecs[i].exp_err});
            if (vecs[i].stop) begin
                @(negedge clk);
                chk($sformatf("v%0d_bus_idle", i), {30'd0, i2c_scl, i2c_sda}, 32'd3);
            end
        end

        // cmd_valid held high while busy must not start a second transaction
        v = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 9'h1FE, 9'h0AA, 8'h3C, 1'b0, 441};
        issue(v, 300, cyc, nd);
        chk("busy_latency", cyc, 441);
        chk("busy_bus_bits", {23'd0, s_bus}, 32'h0AA);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("busy_done_count", nd, 1);

        // Reset in BIT0 q1: SCL and SDA both driven low beforehand
        @(negedge clk);
        cmd_start = 1'b1; cmd_stop = 1'b0; cmd_read = 1'b0; cmd_nack = 1'b0;
        tx_data = 8'h00; cmd_valid = 1'b1;
        s_plan = 9'h1FE; s_start = 1'b1; arm_cnt++;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (54) @(negedge clk);
        chk("midbit_lines_low", {30'd0, i2c_scl, i2c_sda}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("midbit_rst_lines", {30'd0, i2c_scl, i2c_sda}, 32'd3);
        chk("midbit_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midbit_rst_rx",    {24'd0, rx_data},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("midbit_no_done", {31'd0, done}, 32'd0);

`ifdef I2C_CLK_STRETCH_EN
        // Slave stretches SCL through q2 of bit 3
        fork
            begin
                repeat (172) @(negedge clk);
                s_scl_low = 1'b1;
                repeat (110) @(negedge clk);
                s_scl_low = 1'b0;
            end
        join_none
        v = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA0, 9'h1FE, 9'h140, 8'h00, 1'b0, 558};
        issue(v, 0, cyc, nd);
        extra = (cyc > v.exp_cyc) ? cyc - v.exp_cyc : v.exp_cyc - cyc;
        chk("stretch_latency_window", {31'd0, extra <= 3}, 32'd1);
        chk("stretch_bus_bits", {23'd0, s_bus}, 32'h140);
        chk("stretch_ack_err", {31'd0, ack_err}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
